mat_mul_seq: RTL and testbench

Sequential, resource-shared matrix multiplier computing C = A×B, or C = C + A×B in accumulate mode, for rectangular operands: A is M×K, B is K×N. It is the parametrised successor to the fully parallel square multiplier in the compute datapath. P multiply-accumulate lanes are time-multiplexed over the output, so area scales with P rather than N². A start/busy/done handshake lets a controller sequence back-to-back jobs.

---
 rtl/mat_mul_seq.sv | 146 ++++++++++++++
 tb/tb_mat_mul_seq.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_mul_seq.sv
// Sequential matrix multiplier: C = A*B or C = C + A*B, P MAC lanes shared over the output.
// Latency: L = M*(N/P)*K RUN cycles after the start edge, then one DONE cycle (done pulse).
// No backpressure: start is honoured only in IDLE, otherwise dropped; c holds between jobs.
module mat_mul_seq #(
  parameter int width  = 32,
  parameter int M      = 3,
  parameter int K      = 3,
  parameter int N      = 3,
  parameter int P      = 1,
  parameter int SIGNED = 0,
  parameter int OUT_W  = 2*width + $clog2(K)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     acc_en,
  input  logic [M*K*width-1:0]     a,
  input  logic [K*N*width-1:0]     b,
  output logic [M*N*OUT_W-1:0]     c,
  output logic                     busy,
  output logic                     done
);

  localparam int G  = N / P;
  localparam int IW = (M > 1) ? $clog2(M) : 1;
  localparam int GW = (G > 1) ? $clog2(G) : 1;
  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam logic [IW-1:0] I_LAST = IW'(M - 1);
  localparam logic [GW-1:0] G_LAST = GW'(G - 1);
  localparam logic [KW-1:0] K_LAST = KW'(K - 1);

  generate
    if (N % P != 0) begin : g_bad_lanes
      $error("mat_mul_seq: N must be a multiple of P");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                    state_q, state_d;
  logic [IW-1:0]             i_q;
  logic [GW-1:0]             g_q;
  logic [KW-1:0]             kk_q;
  logic [M*K*width-1:0]      a_q;
  logic [K*N*width-1:0]      b_q;
  logic                      acc_en_q;
  logic [P-1:0][OUT_W-1:0]   acc_q;
  logic [P-1:0][OUT_W-1:0]   sum;
  logic [M*N*OUT_W-1:0]      c_q, c_d;
  logic [width-1:0]          a_el;
  logic                      last_mac;

  // Every lane in a cycle shares the same A element A[i][kk].
  assign a_el     = a_q[(int'(i_q)*K + int'(kk_q))*width +: width];
  assign last_mac = (state_q == RUN) && (i_q == I_LAST) && (g_q == G_LAST) && (kk_q == K_LAST);
  assign c        = c_q;

  generate
    for (genvar p = 0; p < P; p++) begin : g_lane
      logic [width-1:0]   b_el;
      logic [2*width-1:0] a_x, b_x, mul;
      logic [OUT_W-1:0]   prod, seed;

      assign b_el = b_q[(int'(kk_q)*N + int'(g_q)*P + p)*width +: width];
      // Extending both operands to 2*width makes the truncated product the exact
      // two's-complement (or unsigned) result, so one multiplier serves both modes.
      assign a_x  = (SIGNED != 0) ? {{width{a_el[width-1]}}, a_el} : {{width{1'b0}}, a_el};
      assign b_x  = (SIGNED != 0) ? {{width{b_el[width-1]}}, b_el} : {{width{1'b0}}, b_el};
      assign mul  = a_x * b_x;
      assign prod = (SIGNED != 0) ? OUT_W'($signed(mul)) : OUT_W'(mul);
      // kk=0 starts a fresh dot product: seed from zero or from the current c element.
      assign seed = (kk_q == '0)
                    ? (acc_en_q ? c_q[(int'(i_q)*N + int'(g_q)*P + p)*OUT_W +: OUT_W] : '0)
                    : acc_q[p];
      assign sum[p] = seed + prod;
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d = state_q;
    busy    = (state_q == RUN);
    done    = (state_q == DONE);
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_mac) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write-back of all P lanes on the last inner-index cycle of a column group.
  always_comb begin
    c_d = c_q;
    if ((state_q == RUN) && (kk_q == K_LAST)) begin
      for (int p = 0; p < P; p++) begin
        c_d[(int'(i_q)*N + int'(g_q)*P + p)*OUT_W +: OUT_W] = sum[p];
      end
    end
  end

  // Operand latch on accept; loop counters, accumulators and c update while running.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      acc_en_q <= 1'b0;
      i_q      <= '0;
      g_q      <= '0;
      kk_q     <= '0;
      acc_q    <= '0;
      c_q      <= '0;
    end else if (state_q == IDLE) begin
      if (start) begin
        a_q      <= a;
        b_q      <= b;
        acc_en_q <= acc_en;
        i_q      <= '0;
        g_q      <= '0;
        kk_q     <= '0;
        acc_q    <= '0;
      end
    end else if (state_q == RUN) begin
      acc_q <= sum;
      c_q   <= c_d;
      if (kk_q == K_LAST) begin
        kk_q <= '0;
        if (g_q == G_LAST) begin
          g_q <= '0;
          i_q <= (i_q == I_LAST) ? '0 : i_q + 1'b1;
        end else begin
          g_q <= g_q + 1'b1;
        end
      end else begin
        kk_q <= kk_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mat_mul_seq.sv
// Bench for mat_mul_seq: four configurations (3x3x3 P=1, 2x3x2 P=2, 1x1x1 signed/unsigned).
// Table vectors plus randomized jobs checked against a plain matrix-product model.
// Handshake, accumulate, reset-mid-job and reset-vs-start corner cases are hand-sequenced.
module tb_mat_mul_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst0, rst1;
  logic [2:0]   start_v;
  logic         acc0, acc1, acc2;
  logic [287:0] a0, b0;
  logic [593:0] c0;
  logic         busy0, done0;
  logic [47:0]  a1, b1;
  logic [71:0]  c1;
  logic         busy1, done1;
  logic [7:0]   a2, b2;
  logic [15:0]  c2, c3;
  logic         busy2, done2, busy3, done3;
  logic [2:0]   busy_v, done_v;

  assign busy_v = {busy2, busy1, busy0};
  assign done_v = {done2, done1, done0};

  mat_mul_seq u0 (.clk(clk), .rst(rst0), .start(start_v[0]), .acc_en(acc0),
                  .a(a0), .b(b0), .c(c0), .busy(busy0), .done(done0));
  mat_mul_seq #(.width(8), .M(2), .K(3), .N(2), .P(2)) u1 (
                  .clk(clk), .rst(rst1), .start(start_v[1]), .acc_en(acc1),
                  .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1));
  mat_mul_seq #(.width(8), .M(1), .K(1), .N(1), .P(1), .SIGNED(1)) u2 (
                  .clk(clk), .rst(rst0), .start(start_v[2]), .acc_en(acc2),
                  .a(a2), .b(b2), .c(c2), .busy(busy2), .done(done2));
  mat_mul_seq #(.width(8), .M(1), .K(1), .N(1), .P(1), .SIGNED(0)) u3 (
                  .clk(clk), .rst(rst0), .start(start_v[2]), .acc_en(acc2),
                  .a(a2), .b(b2), .c(c3), .busy(busy3), .done(done3));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  // Reference models: plain matrix products in the output width (wraps modulo 2^OUT_W).
  function automatic logic [593:0] mdl0(input logic [287:0] av, input logic [287:0] bv,
                                        input logic ae, input logic [593:0] cp);
    logic [593:0] r;
    logic [65:0]  s;
    r = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        s = ae ? cp[(i*3+j)*66 +: 66] : 66'd0;
        for (int k = 0; k < 3; k++)
          s = s + 66'(av[(i*3+k)*32 +: 32]) * 66'(bv[(k*3+j)*32 +: 32]);
        r[(i*3+j)*66 +: 66] = s;
      end
    return r;
  endfunction

  function automatic logic [71:0] mdl1(input logic [47:0] av, input logic [47:0] bv,
                                       input logic ae, input logic [71:0] cp);
    logic [71:0] r;
    logic [17:0] s;
    r = '0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        s = ae ? cp[(i*2+j)*18 +: 18] : 18'd0;
        for (int k = 0; k < 3; k++)
          s = s + 18'(av[(i*3+k)*8 +: 8]) * 18'(bv[(k*2+j)*8 +: 8]);
        r[(i*2+j)*18 +: 18] = s;
      end
    return r;
  endfunction

  // Caller raises start_v[w] before a negedge; this follows the job from edge 0.
  task automatic run_mon(input int w, input int L, input bit disturb,
                         output int bcnt, output int dcyc, output int dlen);
    bcnt = 0; dcyc = 0; dlen = 0;
    @(posedge clk);
    for (int n = 1; n <= L + 12; n++) begin
      @(negedge clk);
      start_v = '0;
      if (disturb) begin
        a1 = ~a1; b1 = ~b1; acc1 = ~acc1;
        if (n == 3 || n == L + 1) start_v[w] = 1'b1;
      end
      if (busy_v[w]) bcnt++;
      if (done_v[w]) begin
        dlen++;
        if (dcyc == 0) dcyc = n;
      end
    end
  endtask

  task automatic chk_timing(input string nm, input int L, input int bcnt, input int dcyc, input int dlen);
    chki({nm, "_busy_cycles"}, bcnt, L);
    chki({nm, "_done_cycle"}, dcyc, L + 1);
    chki({nm, "_done_len"}, dlen, 1);
  endtask

  typedef struct {
    logic [47:0] a;
    logic [47:0] b;
    logic        acc;
    logic [71:0] e;
  } vec_t;

  localparam logic [47:0] A_1    = {8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
  localparam logic [47:0] B_1    = {8'd12, 8'd11, 8'd10, 8'd9, 8'd8, 8'd7};
  localparam logic [47:0] A_FF   = 48'hFFFF_FFFF_FFFF;
  localparam logic [71:0] E_1    = {18'd154, 18'd139, 18'd64, 18'd58};
  localparam logic [71:0] E_ACC  = {18'd308, 18'd278, 18'd128, 18'd116};
  localparam logic [71:0] E_FULL = {18'd195075, 18'd195075, 18'd195075, 18'd195075};
  localparam logic [71:0] E_WRAP = {18'd128006, 18'd128006, 18'd128006, 18'd128006};

  vec_t        tbl [6];
  logic [593:0] c0_m;
  logic [71:0]  c1_m;
  logic [15:0]  c2_m, c3_m;
  int           bc, dc, dl, cnt, ps, pu;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{A_1, B_1, 1'b0, E_1};
    tbl[1] = '{A_1, B_1, 1'b1, E_ACC};
    tbl[2] = '{48'd0, A_FF, 1'b0, 72'd0};
    tbl[3] = '{A_FF, A_FF, 1'b0, E_FULL};
    tbl[4] = '{A_FF, A_FF, 1'b1, E_WRAP};
    tbl[5] = '{48'd0, A_FF, 1'b1, E_WRAP};

    rst0 = 1'b1; rst1 = 1'b1; start_v = '0;
    acc0 = 1'b0; acc1 = 1'b0; acc2 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0;
    repeat (3) @(negedge clk);
    rst0 = 1'b0; rst1 = 1'b0;
    @(negedge clk);

    // Reset state.
    chk("rst_busy", 128'({busy0, busy1, busy2, busy3}), 128'd0);
    chk("rst_done", 128'({done0, done1, done2, done3}), 128'd0);
    chk("rst_c0", 128'(c0[127:0]), 128'd0);
    chk("rst_c1", 128'(c1), 128'd0);
    chk("rst_c23", 128'({c2, c3}), 128'd0);
    c0_m = '0; c1_m = '0; c2_m = '0; c3_m = '0;

    // Lane sharing: identity times B on the 3x3x3, P=1 instance.
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 3; k++) a0[(r*3+k)*32 +: 32] = (r == k) ? 32'd1 : 32'd0;
    for (int e = 0; e < 9; e++) b0[e*32 +: 32] = 32'(e + 1);
    start_v[0] = 1'b1;
    run_mon(0, 27, 1'b0, bc, dc, dl);
    chk_timing("ident", 27, bc, dc, dl);
    for (int e = 0; e < 9; e++) chk($sformatf("ident_c%0d", e), 128'(c0[e*66 +: 66]), 128'(e + 1));
    c0_m = c0;

    // Table-driven 2x3x2, P=2 jobs (entry 1 also exercises the handshake disturbances).
    for (int t = 0; t < 6; t++) begin
      a1 = tbl[t].a; b1 = tbl[t].b; acc1 = tbl[t].acc;
      start_v[1] = 1'b1;
      run_mon(1, 6, (t == 1), bc, dc, dl);
      chk_timing($sformatf("tbl%0d", t), 6, bc, dc, dl);
      for (int e = 0; e < 4; e++)
        chk($sformatf("tbl%0d_c%0d", t, e), 128'(c1[e*18 +: 18]), 128'(tbl[t].e[e*18 +: 18]));
    end

    // Reset mid-job: row 0 already written at cycle 4, row 1 still holds old value.
    a1 = A_1; b1 = B_1; acc1 = 1'b1; start_v[1] = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      start_v = '0;
    end
    chk("midjob_partial_c", 128'(c1), 128'({18'd128006, 18'd128006, 18'd128070, 18'd128064}));
    rst1 = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 128'(busy1), 128'd0);
    chk("midrst_c", 128'(c1), 128'd0);
    rst1 = 1'b0;
    cnt = int'(done1);
    repeat (12) begin
      @(negedge clk);
      if (done1) cnt++;
    end
    chki("midrst_no_done", cnt, 0);

    // Reset and start on the same edge: the start is dropped.
    rst1 = 1'b1; start_v[1] = 1'b1;
    @(negedge clk);
    cnt = int'(busy1);
    rst1 = 1'b0; start_v = '0;
    repeat (8) begin
      @(negedge clk);
      if (busy1) cnt++;
    end
    chki("rst_start_busy", cnt, 0);

    // Fresh job after the reset.
    a1 = A_1; b1 = B_1; acc1 = 1'b0; start_v[1] = 1'b1;
    run_mon(1, 6, 1'b0, bc, dc, dl);
    chk_timing("fresh", 6, bc, dc, dl);
    chk("fresh_c", 128'(c1), 128'(E_1));
    c1_m = E_1;

    // Randomized 2x3x2 jobs against the model.
    for (int t = 0; t < 6; t++) begin
      a1 = 48'({$urandom, $urandom}); b1 = 48'({$urandom, $urandom});
      acc1 = 1'($urandom_range(0, 1));
      c1_m = mdl1(a1, b1, acc1, c1_m);
      start_v[1] = 1'b1;
      run_mon(1, 6, 1'b0, bc, dc, dl);
      for (int e = 0; e < 4; e++)
        chk($sformatf("rnd1_%0d_c%0d", t, e), 128'(c1[e*18 +: 18]), 128'(c1_m[e*18 +: 18]));
    end

    // Randomized 3x3x3 jobs; the last two use all-ones operands (the second wraps).
    for (int t = 0; t < 6; t++) begin
      if (t >= 4) begin
        a0 = '1; b0 = '1; acc0 = (t == 5);
      end else begin
        for (int e = 0; e < 9; e++) begin
          a0[e*32 +: 32] = $urandom;
          b0[e*32 +: 32] = $urandom;
        end
        acc0 = 1'($urandom_range(0, 1));
      end
      c0_m = mdl0(a0, b0, acc0, c0_m);
      start_v[0] = 1'b1;
      run_mon(0, 27, 1'b0, bc, dc, dl);
      for (int e = 0; e < 9; e++)
        chk($sformatf("rnd0_%0d_c%0d", t, e), 128'(c0[e*66 +: 66]), 128'(c0_m[e*66 +: 66]));
    end

    // Signed vs unsigned 1x1x1.
    a2 = 8'hFD; b2 = 8'h05; acc2 = 1'b0; start_v[2] = 1'b1;
    run_mon(2, 1, 1'b0, bc, dc, dl);
    chk_timing("one", 1, bc, dc, dl);
    chk("signed_c", 128'(c2), 128'(16'hFFF1));
    chk("unsigned_c", 128'(c3), 128'(16'h04F1));
    c2_m = 16'hFFF1; c3_m = 16'h04F1;
    for (int t = 0; t < 6; t++) begin
      a2 = (t == 0) ? 8'h80 : 8'($urandom);
      b2 = (t == 0) ? 8'h7F : 8'($urandom);
      acc2 = (t == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      ps = int'($signed(a2)) * int'($signed(b2));
      pu = int'(a2) * int'(b2);
      c2_m = acc2 ? c2_m + 16'(ps) : 16'(ps);
      c3_m = acc2 ? c3_m + 16'(pu) : 16'(pu);
      start_v[2] = 1'b1;
      run_mon(2, 1, 1'b0, bc, dc, dl);
      chk($sformatf("rnd_signed_%0d", t), 128'(c2), 128'(c2_m));
      chk($sformatf("rnd_unsigned_%0d", t), 128'(c3), 128'(c3_m));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
